// File: rtl/branch_resolve_pc.sv
// Fetch PC steering and mem-stage branch resolution; BRANCH_RESOLVE_STATS_EN builds resolve/mispredict counters.
// Latency: a mispredict is detected in mem and redirect+flush appear the next cycle; stall freezes all state and masks flush.
module branch_resolve_pc #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          TRACK_DEPTH  = 2   // legal range 1..4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_decode_sig,
  input  logic [31:0] decode_pc,
  input  logic        prediction,
  input  logic [31:0] branch_addr,
  input  logic        branch_mem_sig,
  input  logic        actual_branch_decision,
  output logic [31:0] pc_out,
  output logic        flush,
  output logic        mispredict,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
);

  typedef struct packed {
    logic        vld;
    logic        pred;
    logic [31:0] fallthrough;
    logic [31:0] target;
  } track_t;

  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_REDIRECT = 1'b1;

  logic [0:0]  state_q;
  logic [0:0]  state_d;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] seq_pc;
  logic [31:0] recovery_pc;
  track_t      track_q [TRACK_DEPTH];
  track_t      mem_entry;
  track_t      load_entry;
  logic        resolve_vld;
  logic        mismatch;

  assign mem_entry   = track_q[TRACK_DEPTH-1];
  assign resolve_vld = branch_mem_sig && mem_entry.vld;
  assign mismatch    = resolve_vld && (mem_entry.pred ^ actual_branch_decision);
  assign recovery_pc = actual_branch_decision ? mem_entry.target : mem_entry.fallthrough;
  assign seq_pc      = pc_q + 32'd4;

  // Decode holds a squashed instruction during REDIRECT, so its branch is not tracked.
  always_comb begin
    load_entry             = '0;
    load_entry.vld         = branch_decode_sig && (state_q == ST_RUN);
    load_entry.pred        = prediction;
    load_entry.fallthrough = decode_pc + 32'd4;
    load_entry.target      = branch_addr;
  end

  always_comb begin
    pc_d = seq_pc;
    if (mismatch) begin
      pc_d = recovery_pc;
    end else if ((state_q == ST_RUN) && prediction) begin
      pc_d = branch_addr;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:      state_d = mismatch ? ST_REDIRECT : ST_RUN;
      ST_REDIRECT: state_d = ST_RUN;
      default:     state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_VECTOR;
      state_q <= ST_RUN;
    end else if (!stall) begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  // A mismatch squashes every younger in-flight branch, including the one in decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TRACK_DEPTH; i++) begin
        track_q[i] <= '0;
      end
    end else if (!stall) begin
      if (mismatch) begin
        for (int i = 0; i < TRACK_DEPTH; i++) begin
          track_q[i] <= '0;
        end
      end else begin
        track_q[0] <= load_entry;
        for (int i = 1; i < TRACK_DEPTH; i++) begin
          track_q[i] <= track_q[i-1];
        end
      end
    end
  end

  assign pc_out     = pc_q;
  assign flush      = (state_q == ST_REDIRECT) && !stall;
  assign mispredict = (state_q == ST_REDIRECT) && !stall;

`ifdef BRANCH_RESOLVE_STATS_EN
  logic [31:0] branches_q;
  logic [31:0] mispredicts_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      branches_q    <= '0;
      mispredicts_q <= '0;
    end else if (!stall) begin
      if (resolve_vld && (branches_q != 32'hFFFF_FFFF)) begin
        branches_q <= branches_q + 32'd1;
      end
      if (mismatch && (mispredicts_q != 32'hFFFF_FFFF)) begin
        mispredicts_q <= mispredicts_q + 32'd1;
      end
    end
  end

  assign stat_branches    = branches_q;
  assign stat_mispredicts = mispredicts_q;
`else
  assign stat_branches    = 32'h0;
  assign stat_mispredicts = 32'h0;
`endif

endmodule

// File: tb/tb_branch_resolve_pc.sv
// Scoreboard bench for branch_resolve_pc: stimulus pushes model predictions, a negedge monitor pops and compares.
module tb_branch_resolve_pc;
  localparam int          D  = 2;
  localparam logic [31:0] RV = 32'h0000_0000;
`ifdef BRANCH_RESOLVE_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_decode_sig;
  logic [31:0] decode_pc;
  logic        prediction;
  logic [31:0] branch_addr;
  logic        branch_mem_sig;
  logic        actual_branch_decision;
  logic [31:0] pc_out;
  logic        flush;
  logic        mispredict;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  always #5 clk = ~clk;

  branch_resolve_pc #(.RESET_VECTOR(RV), .TRACK_DEPTH(D)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .stall                  (stall),
    .branch_decode_sig      (branch_decode_sig),
    .decode_pc              (decode_pc),
    .prediction             (prediction),
    .branch_addr            (branch_addr),
    .branch_mem_sig         (branch_mem_sig),
    .actual_branch_decision (actual_branch_decision),
    .pc_out                 (pc_out),
    .flush                  (flush),
    .mispredict             (mispredict),
    .stat_branches          (stat_branches),
    .stat_mispredicts       (stat_mispredicts)
  );

  typedef struct {
    logic [31:0] pc;
    logic        fl;
    logic        mp;
    logic [31:0] nb;
    logic [31:0] nm;
  } exp_t;

  // In-flight branch as the model sees it: age counts unstalled cycles since decode.
  typedef struct {
    int          age;
    logic        pred;
    logic [31:0] ft;
    logic [31:0] tgt;
  } pend_t;

  exp_t        exp_q[$];
  pend_t       pend[$];
  logic [31:0] m_pc;
  bit          m_redir;
  logic [31:0] m_nb;
  logic [31:0] m_nm;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int mem_idx();
    for (int i = 0; i < pend.size(); i++) begin
      if (pend[i].age == D-1) return i;
    end
    return -1;
  endfunction

  task automatic step(input bit st, input bit bd, input logic [31:0] dpc, input bit pr,
                      input logic [31:0] ba, input bit bm, input bit act);
    exp_t        e;
    pend_t       keep[$];
    pend_t       p;
    int          mi;
    bit          mis;
    logic [31:0] nxt;
    stall = st; branch_decode_sig = bd; decode_pc = dpc; prediction = pr;
    branch_addr = ba; branch_mem_sig = bm; actual_branch_decision = act;
    e.pc = m_pc;
    e.fl = m_redir && !st;
    e.mp = m_redir && !st;
    e.nb = STATS_EN ? m_nb : 32'h0;
    e.nm = STATS_EN ? m_nm : 32'h0;
    exp_q.push_back(e);
    if (!st) begin
      mi  = mem_idx();
      mis = 1'b0;
      nxt = m_pc + 32'd4;
      if (bm && mi >= 0) begin
        if (m_nb != 32'hFFFF_FFFF) m_nb = m_nb + 32'd1;
        if (pend[mi].pred != act) begin
          mis = 1'b1;
          nxt = act ? pend[mi].tgt : pend[mi].ft;
          if (m_nm != 32'hFFFF_FFFF) m_nm = m_nm + 32'd1;
        end
      end
      if (!mis && !m_redir && pr) nxt = ba;
      if (mis) begin
        pend.delete();
      end else begin
        foreach (pend[i]) begin
          if (pend[i].age != D-1) begin
            p = pend[i];
            p.age = p.age + 1;
            keep.push_back(p);
          end
        end
        if (bd && !m_redir) begin
          p.age = 0; p.pred = pr; p.ft = dpc + 32'd4; p.tgt = ba;
          keep.push_back(p);
        end
        pend = keep;
      end
      m_pc    = nxt;
      m_redir = mis;
    end
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pc_out", pc_out, e.pc);
        check("flush", 32'(flush), 32'(e.fl));
        check("mispredict", 32'(mispredict), 32'(e.mp));
        check("stat_branches", stat_branches, e.nb);
        check("stat_mispredicts", stat_mispredicts, e.nm);
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time budget expired");
    $fatal(1, "timeout");
  end

  bit          r_st, r_bd, r_pr, r_bm, r_act;
  logic [31:0] r_dpc, r_ba;

  initial begin : stimulus
    reset = 1'b1; stall = 1'b1; branch_decode_sig = 1'b0; decode_pc = '0; prediction = 1'b0;
    branch_addr = '0; branch_mem_sig = 1'b0; actual_branch_decision = 1'b0;
    m_pc = RV; m_redir = 1'b0; m_nb = '0; m_nm = '0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    check("reset_pc", pc_out, RV);
    check("reset_flush", 32'(flush), 32'h0);

    // Stalled hold, then a mem-stage branch with no tracked entry is ignored.
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
    repeat (3) idle();
    check("seq_pc", pc_out, 32'h10);

    // Correctly predicted not-taken branch.
    step(1'b0, 1'b1, 32'h100, 1'b0, 32'h140, 1'b0, 1'b0);
    idle();
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    check("nt_ok_pc", pc_out, 32'h1C);

    // Predicted taken, actually not taken.
    step(1'b0, 1'b1, 32'h200, 1'b1, 32'h280, 1'b0, 1'b0);
    check("taken_pred_pc", pc_out, 32'h280);
    idle();
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    check("recover_ft_pc", pc_out, 32'h204);
    check("recover_ft_flush", 32'(flush), 32'h1);
    idle();

    // Predicted not taken, actually taken; decode branches in detect/redirect cycles dropped.
    step(1'b0, 1'b1, 32'h300, 1'b0, 32'h3F0, 1'b0, 1'b0);
    idle();
    step(1'b0, 1'b1, 32'h500, 1'b1, 32'h600, 1'b1, 1'b1);
    check("recover_tgt_pc", pc_out, 32'h3F0);
    step(1'b0, 1'b1, 32'h504, 1'b1, 32'h700, 1'b0, 1'b0);
    check("redirect_pred_ignored", pc_out, 32'h3F4);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    check("dropped_not_tracked", pc_out, 32'h3FC);

    // Stall over the detection cycle.
    step(1'b0, 1'b1, 32'h3FC, 1'b0, 32'h480, 1'b0, 1'b0);
    idle();
    repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
    check("stall_hold_pc", pc_out, 32'h404);
    check("stall_flush_low", 32'(flush), 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
    check("post_stall_pc", pc_out, 32'h480);
    check("post_stall_flush", 32'(flush), 32'h1);
    idle();

    // PC wrap at the top of the address space.
    step(1'b0, 1'b1, 32'h484, 1'b1, 32'hFFFF_FFF8, 1'b0, 1'b0);
    idle();
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
    check("wrap_pc", pc_out, 32'h0);

    for (int c = 0; c < 3000; c++) begin
      r_st  = ($urandom_range(7) == 0);
      r_bd  = ($urandom_range(3) == 0);
      r_pr  = r_bd ? 1'($urandom_range(1)) : 1'b0;
      r_dpc = $urandom() & 32'hFFFF_FFFC;
      r_ba  = $urandom() & 32'hFFFF_FFFC;
      r_bm  = (mem_idx() >= 0) ? ($urandom_range(7) != 0) : ($urandom_range(7) == 0);
      r_act = 1'($urandom_range(1));
      step(r_st, r_bd, r_dpc, r_pr, r_ba, r_bm, r_act);
    end
    idle();
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
